// File: rtl/gray_run_ctrl.sv
// gray_run_ctrl
//   Run controller for the Gray counter datapath. On start it clears the
//   counter for one cycle and then issues exactly tgt enable cycles.
//   Pause/resume and abort are supported. It also watches the counter's
//   Gray output for legal single-bit steps.
//
// Ports
//   clk        rising-edge clock
//   reset_L    asynchronous reset, active HIGH (name kept from the original)
//   start      begin a run (sampled in IDLE only)
//   stop       abort the run (highest priority)
//   pause      freeze counting (RUN only)
//   resume     continue counting (PAUSE only)
//   target     run length, latched on accepted start; 0 means 2^CNT_W
//   gray_in    Gray output of the counter
//   cnt_enable counter enable
//   cnt_clear  counter synchronous clear
//   busy       high in CLEAR, RUN or PAUSE
//   done       one-cycle pulse when a run completes
//   aborted    one-cycle pulse when stop ends a run
//   steps      enable cycles issued in the current run (CNT_W+1 bits)
//   err_gray   sticky Gray-sequence error
module gray_run_ctrl #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             resume,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] gray_in,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W:0]   steps,
  output logic             err_gray
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W:0]   tgt, tgt_nxt;
  logic [CNT_W:0]   steps_nxt, steps_inc;
  logic             run_last;
  logic             abort_evt;
  logic             accept_start;

  logic             en_nxt, clr_nxt, busy_nxt, done_nxt, aborted_nxt, err_nxt;

  logic             en_d, clr_d;
  logic [CNT_W-1:0] g_prev;
  logic [CNT_W-1:0] g_diff;
  logic             one_bit;
  logic             viol;

  assign accept_start = (state == S_IDLE) && start;
  assign steps_inc    = steps + (CNT_W+1)'(1);
  // Compare at full width so a run of 2^CNT_W terminates correctly.
  assign run_last     = (steps_inc == tgt);

  // State register
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    abort_evt = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (stop) begin
          state_nxt = S_IDLE;
          abort_evt = 1'b1;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
          abort_evt = 1'b1;
        end else if (run_last) begin
          state_nxt = S_DONE;
        end else if (pause) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_nxt = S_IDLE;
          abort_evt = 1'b1;
        end else if (resume && !pause) begin
          state_nxt = S_RUN;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything is registered so outputs
  // line up with the state they describe.
  always_comb begin
    en_nxt      = (state_nxt == S_RUN);
    clr_nxt     = (state_nxt == S_CLEAR);
    busy_nxt    = (state_nxt == S_CLEAR) || (state_nxt == S_RUN) ||
                  (state_nxt == S_PAUSE);
    done_nxt    = (state_nxt == S_DONE);
    aborted_nxt = abort_evt;

    tgt_nxt   = tgt;
    steps_nxt = steps;
    if (accept_start) begin
      tgt_nxt   = (target == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, target};
      steps_nxt = '0;
    end else if (state == S_RUN) begin
      // The edge leaving RUN (pause, stop or done) still counts its cycle.
      steps_nxt = steps_inc;
    end

    if (accept_start) err_nxt = 1'b0;
    else              err_nxt = err_gray | ((state != S_IDLE) && viol);
  end

  // Gray checker: history of the previous cycle's controls and code.
  assign g_diff  = gray_in ^ g_prev;
  assign one_bit = (g_diff != '0) && ((g_diff & (g_diff - CNT_W'(1))) == '0);

  always_comb begin
    viol = 1'b0;
    if (clr_d)     viol = (gray_in != '0);
    else if (en_d) viol = !one_bit;
    else           viol = (gray_in != g_prev);
  end

  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      cnt_enable <= 1'b0;
      cnt_clear  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      err_gray   <= 1'b0;
      steps      <= '0;
      tgt        <= '0;
      en_d       <= 1'b0;
      clr_d      <= 1'b0;
      g_prev     <= '0;
    end else begin
      cnt_enable <= en_nxt;
      cnt_clear  <= clr_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
      err_gray   <= err_nxt;
      steps      <= steps_nxt;
      tgt        <= tgt_nxt;
      en_d       <= cnt_enable;
      clr_d      <= cnt_clear;
      g_prev     <= gray_in;
    end
  end

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Testbench for gray_run_ctrl: a behavioural 5-bit Gray counter is attached
// to the controller; directed vectors plus hand-written multi-cycle cases.
module tb_gray_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, pause, resume;
  logic [4:0] target;
  logic [4:0] gray_in;
  logic       cnt_enable, cnt_clear, busy, done, aborted, err_gray;
  logic [5:0] steps;

  logic [4:0] cnt;
  logic       force_en;
  logic [4:0] force_val;

  int n_checks = 0;
  int n_fail   = 0;
  int en_seen, done_seen, ab_seen;

  always #5 clk = ~clk;

  gray_run_ctrl #(.CNT_W(5)) dut (
    .clk       (clk),
    .reset_L   (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .resume    (resume),
    .target    (target),
    .gray_in   (gray_in),
    .cnt_enable(cnt_enable),
    .cnt_clear (cnt_clear),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .steps     (steps),
    .err_gray  (err_gray)
  );

  // Gray counter model with synchronous clear and enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (cnt_clear)  cnt <= '0;
    else if (cnt_enable) cnt <= cnt + 5'd1;
  end

  assign gray_in = force_en ? force_val : (cnt ^ (cnt >> 1));

  typedef struct {
    logic        st, sp, pa, re;
    logic [4:0]  tg;
    logic [16:0] exp;   // {en, clr, busy, done, aborted, err, steps[5:0], gray[4:0]}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic pa,
                              input logic re, input logic [4:0] tg,
                              input logic en, input logic clr, input logic bz,
                              input logic dn, input logic ab,
                              input logic [5:0] s, input logic [4:0] g);
    vec_t v;
    v.st  = st; v.sp = sp; v.pa = pa; v.re = re; v.tg = tg;
    v.exp = {en, clr, bz, dn, ab, 1'b0, s, g};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cnt_enable) en_seen++;
    if (done)       done_seen++;
    if (aborted)    ab_seen++;
  endtask

  task automatic clear_counts();
    en_seen = 0; done_seen = 0; ab_seen = 0;
  endtask

  function automatic logic [16:0] outs();
    return {cnt_enable, cnt_clear, busy, done, aborted, err_gray, steps, gray_in};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 0; stop = 0; pause = 0; resume = 0; target = '0;
    force_en = 0; force_val = '0;
    #1;
    check("reset_outputs", 32'(outs()), 32'(0));
    #11 rst = 1'b0;

    // target=5 run (pause on last step loses to DONE), start/stop in DONE
    // and IDLE ignored, stop after 4 enables, stop+pause, stop in CLEAR.
    vq.push_back(mk(1,0,0,0,5'd5, 0,1,1,0,0, 6'd0, 5'b00000));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd0, 5'b00000));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd1, 5'b00001));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd2, 5'b00011));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd3, 5'b00010));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd4, 5'b00110));
    vq.push_back(mk(0,0,1,0,5'd0, 0,0,0,1,0, 6'd5, 5'b00111));
    vq.push_back(mk(1,1,0,0,5'd9, 0,0,0,0,0, 6'd5, 5'b00111));
    vq.push_back(mk(0,1,0,0,5'd9, 0,0,0,0,0, 6'd5, 5'b00111));
    vq.push_back(mk(1,0,0,0,5'd8, 0,1,1,0,0, 6'd0, 5'b00111));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd0, 5'b00000));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd1, 5'b00001));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd2, 5'b00011));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd3, 5'b00010));
    vq.push_back(mk(0,1,0,0,5'd0, 0,0,0,0,1, 6'd4, 5'b00110));
    vq.push_back(mk(0,0,0,0,5'd0, 0,0,0,0,0, 6'd4, 5'b00110));
    vq.push_back(mk(1,0,0,0,5'd8, 0,1,1,0,0, 6'd0, 5'b00110));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd0, 5'b00000));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd1, 5'b00001));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd2, 5'b00011));
    vq.push_back(mk(0,0,0,0,5'd0, 1,0,1,0,0, 6'd3, 5'b00010));
    vq.push_back(mk(0,1,1,0,5'd0, 0,0,0,0,1, 6'd4, 5'b00110));
    vq.push_back(mk(0,0,0,0,5'd0, 0,0,0,0,0, 6'd4, 5'b00110));
    vq.push_back(mk(1,0,0,0,5'd3, 0,1,1,0,0, 6'd0, 5'b00110));
    vq.push_back(mk(0,1,0,0,5'd0, 0,0,0,0,1, 6'd0, 5'b00000));
    vq.push_back(mk(0,0,0,0,5'd0, 0,0,0,0,0, 6'd0, 5'b00000));

    clear_counts();
    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].st; stop = vq[i].sp; pause = vq[i].pa; resume = vq[i].re;
      target = vq[i].tg;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
    end
    start = 0; stop = 0; pause = 0; resume = 0;
    check("table_done_pulses", 32'(done_seen), 32'(1));
    check("table_abort_pulses", 32'(ab_seen), 32'(3));

    // target=0: full 32-step run with wrap to 00000.
    clear_counts();
    start = 1; target = 5'd0;
    step();
    start = 0;
    repeat (40) step();
    check("t0_enables", 32'(en_seen), 32'(32));
    check("t0_done", 32'(done_seen), 32'(1));
    check("t0_steps", 32'(steps), 32'(32));
    check("t0_gray", 32'(gray_in), 32'(0));
    check("t0_err", 32'(err_gray), 32'(0));

    // target=10 with a 4-cycle pause after 3 enables.
    clear_counts();
    start = 1; target = 5'd10;
    step();
    start = 0;
    repeat (3) step();
    pause = 1;
    step();
    pause = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pause_hold%0d", i), 32'({cnt_enable, busy, steps}), 32'({1'b0, 1'b1, 6'd3}));
      if (i < 3) step();
    end
    resume = 1;
    step();
    resume = 0;
    repeat (12) step();
    check("pause_enables", 32'(en_seen), 32'(10));
    check("pause_done", 32'(done_seen), 32'(1));
    check("pause_steps", 32'(steps), 32'(10));
    check("pause_gray", 32'(gray_in), 32'(5'b01111));

    // Illegal Gray step 00001 -> 00010 injected during RUN.
    clear_counts();
    start = 1; target = 5'd6;
    step();
    start = 0;
    step();
    step();
    check("err_gray_seen_a", 32'(gray_in), 32'(5'b00001));
    step();
    force_en = 1; force_val = 5'b00010;
    check("err_before", 32'(err_gray), 32'(0));
    step();
    force_en = 0;
    check("err_set", 32'(err_gray), 32'(1));
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) check("err_in_done", 32'(err_gray), 32'(1));
    end
    check("err_done_pulse", 32'(done_seen), 32'(1));
    check("err_sticky_idle", 32'(err_gray), 32'(1));
    start = 1; target = 5'd2;
    step();
    start = 0;
    check("err_cleared_by_start", 32'(err_gray), 32'(0));
    repeat (6) step();
    check("err_clean_run", 32'({err_gray, steps}), 32'({1'b0, 6'd2}));

    // Asynchronous reset between clock edges during RUN.
    start = 1; target = 5'd9;
    step();
    start = 0;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({cnt_enable, cnt_clear, busy, done, aborted, err_gray, steps}), 32'(0));
    #10 rst = 1'b0;
    check("reset_held_outputs", 32'({cnt_enable, cnt_clear, busy, done, aborted, err_gray, steps}), 32'(0));
    clear_counts();
    start = 1; target = 5'd3;
    step();
    start = 0;
    repeat (8) step();
    check("post_reset_enables", 32'(en_seen), 32'(3));
    check("post_reset_done", 32'(done_seen), 32'(1));
    check("post_reset_aborts", 32'(ab_seen), 32'(0));
    check("post_reset_steps", 32'(steps), 32'(3));
    check("post_reset_gray", 32'({err_gray, gray_in}), 32'({1'b0, 5'b00010}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_run_ctrl.md
Name: gray_run_ctrl

Overview:
Run controller for the 5-bit Gray counter datapath. On `start` it clears the counter, then issues exactly N enable cycles, with pause/resume and abort. It also checks the counter's Gray output for legal single-bit transitions. It sits between the test/control logic and the Gray counter instance and drives that counter's `enable` and reset inputs.

Parameters:
- `CNT_W`, 5, width of the counter and Gray bus; a run length of 0 means 2^CNT_W.

Ports:
- `clk` input 1: rising-edge clock.
- `reset_L` input 1: asynchronous, active-high reset.
- `start` input 1: begin a run. Sampled only in IDLE.
- `stop` input 1: abort the run. Highest priority.
- `pause` input 1: freeze counting. Valid in RUN.
- `resume` input 1: continue counting. Valid in PAUSE.
- `target` input CNT_W: run length, latched on accepted `start`; 0 means 32.
- `gray_in` input CNT_W: `salida_gray` from the counter.
- `cnt_enable` output 1: drives the counter's `enable`.
- `cnt_clear` output 1: drives the counter's synchronous clear.
- `busy` output 1: high in CLEAR, RUN or PAUSE.
- `done` output 1: one-cycle pulse when a run completes.
- `aborted` output 1: one-cycle pulse when `stop` ends a run.
- `steps` output CNT_W+1: number of enable cycles issued in the current run.
- `err_gray` output 1: sticky Gray-sequence error.

Behaviour:
- Reset: `reset_L`=1 asynchronously forces state IDLE. All outputs go to 0, `steps`=0, the latched target is 0 and the checker history is 0.
- All outputs are registered (Moore), so each changes one cycle after the deciding edge.
- States: IDLE, CLEAR, RUN, PAUSE, DONE.
- IDLE:
  - `start`=1 → CLEAR.
  - Latch `tgt` = (`target`==0) ? 2^CNT_W : `target`.
  - Set `steps`=0 and clear `err_gray`.
- CLEAR: `cnt_clear`=1 for exactly one cycle, then → RUN.
- RUN:
  - `cnt_enable`=1 in every RUN cycle.
  - `steps` increments on each edge that ends a RUN cycle.
  - When the increment makes `steps`==`tgt` → DONE. RUN therefore lasts exactly `tgt` cycles.
  - `pause`=1 → PAUSE. That edge still counts the current enable cycle.
  - If `pause` arrives on the last step, DONE wins.
- PAUSE: `cnt_enable`=0 and `steps` holds. `resume`=1 → RUN.
- DONE: `done`=1 for one cycle, then → IDLE. `steps` holds its final value until the next `start`.
- Priority:
  - `stop` beats `pause`, which beats `resume`.
  - `stop` in CLEAR, RUN or PAUSE → IDLE with `aborted`=1 for one cycle. `done` does not pulse, and `cnt_enable` drops on the next cycle.
  - `stop` in IDLE or DONE is ignored.
  - `start` outside IDLE is ignored, including `start` during DONE.
- Gray checker:
  - Each edge registers `en_d`=`cnt_enable`, `clr_d`=`cnt_clear` and `g_prev`=`gray_in`.
  - If `clr_d`=1, require `gray_in`==0.
  - Else if `en_d`=1, require popcount(`gray_in` ^ `g_prev`)==1. This includes the wrap 10000→00000.
  - Else require `gray_in`==`g_prev`.
  - Checks run only while `busy` or in DONE, not in IDLE.
  - A violation sets `err_gray` on the next edge. It stays set until the next accepted `start` or reset.
- Width rules:
  - `steps` is CNT_W+1 bits so it can hold 32.
  - The `steps`==`tgt` compare is done at CNT_W+1 bits.
- Reset asserted mid-run: immediate return to IDLE with no `done` or `aborted` pulse.

Test Plan:
- `target`=5, `start` pulse, counter attached:
  - `cnt_clear` high for 1 cycle, then `cnt_enable` high for exactly 5 cycles.
  - `done` pulses once, `steps`=6'd5, `gray_in` settles at 00111, `err_gray`=0.
- `target`=0:
  - 32 enable cycles and `steps`=6'd32.
  - `gray_in` walks the full Gray sequence and wraps to 00000 with no error; `done` pulses after the 32nd enable cycle.
- `target`=10, `pause` after 3 enables, held 4 cycles, then `resume`:
  - `cnt_enable` low for 4 cycles and `steps` frozen at 3.
  - Total enable cycles = 10, `done` pulses once, `gray_in` ends at 01111.
- `target`=8, `stop` after 4 enables:
  - Next cycle IDLE, `aborted` pulses, `done` stays 0, `steps`=4, `gray_in`=00110.
  - `stop` together with `pause` gives the same result.
- Bench forces `gray_in` 00001→00010 during RUN:
  - `err_gray`=1 the next cycle and stays 1 through DONE.
  - The next `start` clears it.
- `reset_L` asserted mid-RUN, between clock edges:
  - All outputs 0 immediately and state IDLE.
  - After release, a new `start` runs normally.
